serial_adder: RTL

//   Bit-serial N-bit adder built around the one-bit full_adder cell.
//   - Captures two WIDTH-bit operands and a carry-in on a start pulse.
//   - Adds LSB-first, one bit per clock, through a single full_adder, keeping the carry in a flip-flop.
//   - Presents the registered sum and carry-out with a one-cycle done pulse.
//   - Sits directly upstream of the one-bit cell: it sequences operand bits into it and collects its S/C_out.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_full_adder.sv | 13 +
 rtl/serial_adder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and defaults for the bit-serial adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_t;

  localparam int SA_WIDTH_DEF = 8;

endpackage

// File: rtl/serial_adder_full_adder.sv
// rtl/serial_adder_full_adder.sv - one-bit combinational full adder cell
module full_adder (
  input  logic A,
  input  logic B,
  input  logic C_in,
  output logic S,
  output logic C_out
);

  assign S     = A ^ B ^ C_in;
  assign C_out = (A & B) | (C_in & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder around one full_adder cell
// Optional signed-overflow output V is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             V
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sa_state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             cy;
  logic [CNT_W-1:0] cnt;

  logic fa_s;
  logic fa_c_out;
  logic accept;
  logic last_bit;

  full_adder u_fa (
    .A     (a_sh[0]),
    .B     (b_sh[0]),
    .C_in  (cy),
    .S     (fa_s),
    .C_out (fa_c_out)
  );

  assign accept   = (state == IDLE) && start;
  assign last_bit = (state == SHIFT) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand, sum and carry shifters; start is only honoured from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      s_sh <= '0;
      cy   <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      a_sh <= A;
      b_sh <= B;
      s_sh <= '0;
      cy   <= C_in;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      a_sh <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh <= {1'b0, b_sh[WIDTH-1:1]};
      s_sh <= {fa_s, s_sh[WIDTH-1:1]};
      cy   <= fa_c_out;
      cnt  <= cnt + 1'b1;
    end
  end

  // Result registers update only on the final shift and hold through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S     <= '0;
      C_out <= 1'b0;
    end else if (last_bit) begin
      S     <= {fa_s, s_sh[WIDTH-1:1]};
      C_out <= fa_c_out;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // On the last bit cy is the carry into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      V <= 1'b0;
    end else if (last_bit) begin
      V <= cy ^ fa_c_out;
    end
  end
`endif

endmodule
